// File: rtl/handshake_req_src.sv
// Source-side controller for a four-phase req/ack crossing: captures a payload,
// drives req_src until the resynchronized ack returns, then waits for ack to drop.
module handshake_req_src #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk_src,
  input  logic              rst_src,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  output logic              send_ready,
  output logic              req_src,
  output logic [DATA_W-1:0] data_src,
  input  logic              ack_in,
  output logic              done,
  output logic              timeout_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_HI = 2'd1,
    ST_REQ_LO = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [SYNC_STAGES-1:0]  sync_r;
  logic                    ack_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic                    to_hit_s;
  logic                    accept_s;
  logic                    req_nxt_s;
  logic                    done_nxt_s;
  logic                    err_nxt_s;
  logic [DATA_W-1:0]       data_nxt_s;

  assign ack_s      = sync_r[SYNC_STAGES-1];
  assign send_ready = (state_r == ST_IDLE);
  assign accept_s   = send_valid && send_ready;
  assign to_hit_s   = TO_EN && (cnt_r == TO_LAST);

  // ack_in resynchronizer chain; only the last stage is ever observed
  always_ff @(posedge clk_src or posedge rst_src) begin
    if (rst_src) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ack_in};
    end
  end

  // state and timeout counter registers
  always_ff @(posedge clk_src or posedge rst_src) begin
    if (rst_src) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // next-state logic: an exit condition always beats a coincident timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_REQ_HI;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ_HI: begin
        if (ack_s) begin
          state_nxt_s = ST_REQ_LO;
        end else if (to_hit_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_REQ_HI;
        end
      end
      ST_REQ_LO: begin
        if (!ack_s) begin
          state_nxt_s = ST_IDLE;
        end else if (to_hit_s) begin
          state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = ST_REQ_LO;
        end
      end
      ST_ERR: begin
        if (err_clr && !ack_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // counter restarts on every state change and only runs while waiting on ack
  always_comb begin
    cnt_nxt_s = {CNT_W{1'b0}};
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (TO_EN && ((state_r == ST_REQ_HI) || (state_r == ST_REQ_LO))) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  // output next values derived from the upcoming state
  always_comb begin
    req_nxt_s  = (state_nxt_s == ST_REQ_HI);
    done_nxt_s = (state_r == ST_REQ_LO) && (state_nxt_s == ST_IDLE);
    err_nxt_s  = (state_nxt_s == ST_ERR);
    if (accept_s) begin
      data_nxt_s = send_data;
    end else begin
      data_nxt_s = data_src;
    end
  end

  // registered outputs
  always_ff @(posedge clk_src or posedge rst_src) begin
    if (rst_src) begin
      req_src     <= 1'b0;
      data_src    <= {DATA_W{1'b0}};
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_src     <= req_nxt_s;
      data_src    <= data_nxt_s;
      done        <= done_nxt_s;
      timeout_err <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_handshake_req_src.sv
// Directed bench for handshake_req_src (DATA_W=8, SYNC_STAGES=2, TIMEOUT=10):
// a per-cycle vector table for the normal handshakes plus hand-written corner sequences.
module tb_handshake_req_src;

  logic       clk_src = 1'b0;
  logic       rst_src;
  logic       send_valid;
  logic [7:0] send_data;
  logic       send_ready;
  logic       req_src;
  logic [7:0] data_src;
  logic       ack_in;
  logic       done;
  logic       timeout_err;
  logic       err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        ack;
    logic        clr;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  handshake_req_src #(
    .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(10), .CNT_W(16)
  ) dut (
    .clk_src(clk_src), .rst_src(rst_src), .send_valid(send_valid),
    .send_data(send_data), .send_ready(send_ready), .req_src(req_src),
    .data_src(data_src), .ack_in(ack_in), .done(done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk_src = ~clk_src;

  // packed {req, data, ready, done, err}
  function automatic logic [11:0] ev(input logic r, input logic [7:0] d,
                                     input logic rd, input logic dn, input logic e);
    return {r, d, rd, dn, e};
  endfunction

  function automatic logic [11:0] obs();
    return {req_src, data_src, send_ready, done, timeout_err};
  endfunction

  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = obs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got req=%b data=%h ready=%b done=%b err=%b, want req=%b data=%h ready=%b done=%b err=%b",
               name, got[11], got[10:3], got[2], got[1], got[0],
               exp[11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic sv, input logic [7:0] sd, input logic ack, input logic clr);
    send_valid = sv;
    send_data  = sd;
    ack_in     = ack;
    err_clr    = clr;
    @(posedge clk_src);
    #1;
  endtask

  task automatic add(input logic sv, input logic [7:0] sd, input logic ack, input logic clr,
                     input logic [11:0] exp);
    vec_t v;
    v.sv = sv; v.sd = sd; v.ack = ack; v.clr = clr; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    // A5 transfer with a 0xFF pulse during REQ_HI, then back-to-back 3C from the done cycle
    add(1'b1, 8'hA5, 1'b0, 1'b0, ev(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b1, 8'hFF, 1'b0, 1'b0, ev(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0));
    add(1'b1, 8'h3C, 1'b0, 1'b0, ev(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b1, ev(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0));
    // stale ack while idle must be ignored
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b1, 1'b0, ev(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0));
    add(1'b0, 8'h00, 1'b0, 1'b0, ev(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0));

    rst_src = 1'b1; send_valid = 1'b0; send_data = 8'h00; ack_in = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk_src);
    #1;
    chk("reset_held", ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    @(negedge clk_src);
    rst_src = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_released", ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      step(tbl[i].sv, tbl[i].sd, tbl[i].ack, tbl[i].clr);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // timeout in REQ_HI; err_clr on the firing edge must not clear the new error
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk($sformatf("to_hi_wait%0d", k), ev(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to_hi_fire", ev(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1));
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("to_hi_err_hold", ev(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to_hi_clear", ev(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0));

    // ack arrives on the very cycle the timeout would fire: exit wins
    step(1'b1, 8'h11, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("coinc_before", ev(1'b1, 8'h11, 1'b0, 1'b0, 1'b0));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("coinc_exit", ev(1'b0, 8'h11, 1'b0, 1'b0, 1'b0));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("coinc_done", ev(1'b0, 8'h11, 1'b1, 1'b1, 1'b0));

    // timeout in REQ_LO with ack stuck high; clear only after ack_s falls
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("to_lo_enter", ev(1'b0, 8'h66, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 9; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("to_lo_wait", ev(1'b0, 8'h66, 1'b0, 1'b0, 1'b0));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("to_lo_fire", ev(1'b0, 8'h66, 1'b0, 1'b0, 1'b1));
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("to_lo_clr_ack_hi", ev(1'b0, 8'h66, 1'b0, 1'b0, 1'b1));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to_lo_clr_sync1", ev(1'b0, 8'h66, 1'b0, 1'b0, 1'b1));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to_lo_clr_sync2", ev(1'b0, 8'h66, 1'b0, 1'b0, 1'b1));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to_lo_released", ev(1'b0, 8'h66, 1'b1, 1'b0, 1'b0));

    // asynchronous reset two cycles into REQ_HI, then a fresh transfer
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_src = 1'b1;
    #1;
    chk("midreset_async", ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    @(negedge clk_src);
    rst_src = 1'b0;
    step(1'b1, 8'h99, 1'b0, 1'b0);
    chk("fresh_accept", ev(1'b1, 8'h99, 1'b0, 1'b0, 1'b0));
    begin
      int k;
      k = 0;
      do begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        k++;
      end while (req_src && k < 10);
      chk("fresh_req_fall", ev(1'b0, 8'h99, 1'b0, 1'b0, 1'b0));
      k = 0;
      do begin
        step(1'b0, 8'h00, 1'b0, 1'b0);
        k++;
      end while (!done && k < 10);
      chk("fresh_done", ev(1'b0, 8'h99, 1'b1, 1'b1, 1'b0));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fresh_done_pulse_end", ev(1'b0, 8'h99, 1'b1, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
